// File: rtl/sm_debug_ctrl_pkg.sv
// rtl/sm_debug_ctrl_pkg.sv - shared state/event encodings and helpers for the debug controller
package sm_debug_ctrl_pkg;

    localparam int DIV_W = 4;
    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HALT = 2'd1,
        S_STEP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        EV_NONE  = 2'd0,
        EV_SHORT = 2'd1,
        EV_LONG  = 2'd2
    } ev_t;

    // Clock-divider increment that wraps from the slowest setting back to the fastest
    function automatic logic [DIV_W-1:0] div_wrap_inc(input logic [DIV_W-1:0] d,
                                                      input logic [DIV_W-1:0] lo,
                                                      input logic [DIV_W-1:0] hi);
        return (d == hi) ? lo : d + 1'b1;
    endfunction

endpackage

// File: rtl/sm_debug_ctrl_if.sv
// rtl/sm_debug_ctrl_if.sv - key inputs and core-control outputs of the debug controller
interface sm_debug_ctrl_if;
    logic       keyMode_n;
    logic       keyStep_n;
    logic       clkEnable;
    logic [3:0] clkDevide;
    logic [4:0] regAddr;
    logic       running;
    logic       stepBusy;

    modport master (
        input  keyMode_n, keyStep_n,
        output clkEnable, clkDevide, regAddr, running, stepBusy
    );

    modport slave (
        output keyMode_n, keyStep_n,
        input  clkEnable, clkDevide, regAddr, running, stepBusy
    );
endinterface

// File: rtl/sm_debug_ctrl_debounce.sv
// rtl/sm_debug_ctrl_debounce.sv - key synchronizer, debouncer and short/long press classifier
module sm_debug_ctrl_debounce
    import sm_debug_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES  = 50000,
    parameter int LONG_CYCLES = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic ev_short,
    output logic ev_long
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;      // accepted key level, 1 = released
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    ev_t           ev_q, ev_d;

    // Synchronize the raw key and accept a new level only after a run of equal samples
    always_comb begin
        sync1_d   = key_n;
        sync2_d   = sync1_q;
        level_d   = level_q;
        deb_cnt_d = '0;
        if (sync2_q != level_q) begin
            if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Time the accepted press: long event once at saturation, short event on an early release
    always_comb begin
        hold_cnt_d = '0;
        ev_d       = EV_NONE;
        if (!level_q) begin
            if (level_d) begin
                ev_d = (hold_cnt_q == HW'(LONG_CYCLES)) ? EV_NONE : EV_SHORT;
            end else if (hold_cnt_q == HW'(LONG_CYCLES)) begin
                hold_cnt_d = hold_cnt_q;
            end else begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (hold_cnt_q == HW'(LONG_CYCLES - 1)) begin
                    ev_d = EV_LONG;
                end
            end
        end
    end

    // Key-path registers; idle state is a released key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            level_q    <= 1'b1;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            ev_q       <= EV_NONE;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            level_q    <= level_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            ev_q       <= ev_d;
        end
    end

    assign ev_short = (ev_q == EV_SHORT);
    assign ev_long  = (ev_q == EV_LONG);

endmodule

// File: rtl/sm_debug_ctrl.sv
// rtl/sm_debug_ctrl.sv - run/halt/step and speed/register-view controller for the schoolMIPS core
module sm_debug_ctrl
    import sm_debug_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES   = 50000,
    parameter int LONG_CYCLES  = 25000000,
    parameter int STEP_LEN     = 262144,
    parameter int DIV_MIN      = 0,
    parameter int DIV_MAX      = 15,
    parameter int DIV_DEFAULT  = 8,
    parameter int REG_DEFAULT  = 2,
    parameter bit RUN_ON_RESET = 1'b1
) (
    input  logic              clkIn,
    input  logic              rst_n,
    sm_debug_ctrl_if.master   dbg
);

    localparam int     SW          = $clog2(STEP_LEN + 1);
    localparam state_t RESET_STATE = RUN_ON_RESET ? S_RUN : S_HALT;

    logic             mode_short, mode_long;
    logic             step_short, step_long;
    state_t           state_q, state_d;
    logic [SW-1:0]    step_cnt_q, step_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [REG_W-1:0] reg_q, reg_d;

    sm_debug_ctrl_debounce #(
        .DEB_CYCLES  (DEB_CYCLES),
        .LONG_CYCLES (LONG_CYCLES)
    ) u_key_mode (
        .clk      (clkIn),
        .rst_n    (rst_n),
        .key_n    (dbg.keyMode_n),
        .ev_short (mode_short),
        .ev_long  (mode_long)
    );

    sm_debug_ctrl_debounce #(
        .DEB_CYCLES  (DEB_CYCLES),
        .LONG_CYCLES (LONG_CYCLES)
    ) u_key_step (
        .clk      (clkIn),
        .rst_n    (rst_n),
        .key_n    (dbg.keyStep_n),
        .ev_short (step_short),
        .ev_long  (step_long)
    );

    // State, step counter, divider and register-view registers
    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RESET_STATE;
            step_cnt_q <= '0;
            div_q      <= DIV_W'(DIV_DEFAULT);
            reg_q      <= REG_W'(REG_DEFAULT);
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            div_q      <= div_d;
            reg_q      <= reg_d;
        end
    end

    // Next state; a mode short wins over a same-cycle step short, and both are ignored mid-burst
    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        case (state_q)
            S_RUN: begin
                if (mode_short) state_d = S_HALT;
            end
            S_HALT: begin
                if (mode_short) begin
                    state_d = S_RUN;
                end else if (step_short) begin
                    state_d    = S_STEP;
                    step_cnt_d = SW'(STEP_LEN - 1);
                end
            end
            S_STEP: begin
                if (step_cnt_q == '0) begin
                    state_d = S_HALT;
                end else begin
                    step_cnt_d = step_cnt_q - 1'b1;
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    // Divider and register-view updates; mode long is applied before a step short in RUN
    always_comb begin
        div_d = mode_long ? DIV_W'(DIV_DEFAULT) : div_q;
        if (state_q == S_RUN && step_short && !mode_short) begin
            div_d = div_wrap_inc(div_d, DIV_W'(DIV_MIN), DIV_W'(DIV_MAX));
        end
        reg_d = reg_q + REG_W'(step_long);
    end

    // Core-facing outputs decoded from the registered state
    always_comb begin
        dbg.clkEnable = 1'b0;
        dbg.running   = 1'b0;
        dbg.stepBusy  = 1'b0;
        case (state_q)
            S_RUN: begin
                dbg.clkEnable = 1'b1;
                dbg.running   = 1'b1;
            end
            S_STEP: begin
                dbg.clkEnable = 1'b1;
                dbg.stepBusy  = 1'b1;
            end
            default: ;
        endcase
    end

    assign dbg.clkDevide = div_q;
    assign dbg.regAddr   = reg_q;

endmodule

// File: tb/tb_sm_debug_ctrl.sv
// tb/tb_sm_debug_ctrl.sv - self-checking bench for sm_debug_ctrl
module tb_sm_debug_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    // press-level reference model
    bit   m_run;
    int   m_div;
    int   m_reg;

    sm_debug_ctrl_if dif ();

    sm_debug_ctrl #(
        .DEB_CYCLES   (4),
        .LONG_CYCLES  (20),
        .STEP_LEN     (8),
        .DIV_DEFAULT  (8),
        .RUN_ON_RESET (1'b1)
    ) dut (
        .clkIn (clk),
        .rst_n (rst_n),
        .dbg   (dif)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b1;
        m_div = 8;
        m_reg = 2;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".running"},   dif.running,   32'(m_run));
        check({tag, ".clkEnable"}, dif.clkEnable, 32'(m_run));
        check({tag, ".stepBusy"},  dif.stepBusy,  0);
        check({tag, ".clkDevide"}, dif.clkDevide, m_div);
        check({tag, ".regAddr"},   dif.regAddr,   m_reg);
    endtask

    // which: bit0 = mode key, bit1 = step key; both keys share one hold time
    task automatic do_press(input int which, input bit is_long, input int hold, input string tag);
        int en_hi   = 0;
        int busy_hi = 0;
        bit prev_run = m_run;
        bit exp_burst = 1'b0;
        if ((which & 1) != 0) dif.keyMode_n = 1'b0;
        if ((which & 2) != 0) dif.keyStep_n = 1'b0;
        tick(hold);
        dif.keyMode_n = 1'b1;
        dif.keyStep_n = 1'b1;
        repeat (26) begin
            tick(1);
            en_hi   += int'(dif.clkEnable);
            busy_hi += int'(dif.stepBusy);
        end
        if (is_long) begin
            if ((which & 1) != 0) m_div = 8;
            if ((which & 2) != 0) m_reg = (m_reg + 1) % 32;
        end else if ((which & 1) != 0) begin
            m_run = !m_run;
        end else if (m_run) begin
            m_div = (m_div == 15) ? 0 : m_div + 1;
        end else begin
            exp_burst = 1'b1;
        end
        if (exp_burst) begin
            check({tag, ".burst_en"},   en_hi,   8);
            check({tag, ".burst_busy"}, busy_hi, 8);
        end else begin
            check({tag, ".no_busy"}, busy_hi, 0);
            if (!prev_run && !m_run) check({tag, ".halt_en"}, en_hi, 0);
        end
        check_state(tag);
    endtask

    initial begin
        int en_hi;
        int busy_hi;
        int guard;
        bit seen;

        dif.keyMode_n = 1'b1;
        dif.keyStep_n = 1'b1;
        rst_n = 1'b0;
        model_reset();
        tick(3);
        check_state("in_reset");
        rst_n = 1'b1;
        tick(2);
        check_state("reset");

        // mode glitch shorter than the debounce window
        dif.keyMode_n = 1'b0;
        tick(3);
        dif.keyMode_n = 1'b1;
        tick(15);
        check_state("glitch");

        do_press(1, 1'b0, 10, "mode_to_halt");
        do_press(2, 1'b0, 10, "step_burst");

        // mode short landing mid-burst is dropped; burst length unchanged
        dif.keyMode_n = 1'b0;
        dif.keyStep_n = 1'b0;
        tick(10);
        dif.keyStep_n = 1'b1;
        en_hi = 0;
        busy_hi = 0;
        repeat (4) begin
            tick(1);
            en_hi   += int'(dif.clkEnable);
            busy_hi += int'(dif.stepBusy);
        end
        dif.keyMode_n = 1'b1;
        repeat (26) begin
            tick(1);
            en_hi   += int'(dif.clkEnable);
            busy_hi += int'(dif.stepBusy);
        end
        check("drop.burst_en", en_hi, 8);
        check("drop.burst_busy", busy_hi, 8);
        check_state("drop");

        do_press(1, 1'b0, 10, "mode_to_run");

        // divider up to the slowest setting, then wrap
        guard = 0;
        while (m_div != 15 && guard < 20) begin
            do_press(2, 1'b0, 10, "div_inc");
            guard++;
        end
        check("div_reached_max", dif.clkDevide, 15);
        do_press(2, 1'b0, 10, "div_wrap");
        check("div_wrapped", dif.clkDevide, 0);
        do_press(1, 1'b1, 30, "mode_long");

        // register view up to 31, then one long hold wraps to 0 exactly once
        guard = 0;
        while (m_reg != 31 && guard < 40) begin
            do_press(2, 1'b1, 25, "reg_inc");
            guard++;
        end
        check("reg_reached_31", dif.regAddr, 31);
        do_press(2, 1'b1, 30, "reg_wrap");
        check("reg_wrapped", dif.regAddr, 0);

        // randomized presses against the model
        for (int i = 0; i < 30; i++) begin
            int which = int'($urandom_range(1, 3));
            bit lng   = 1'($urandom_range(0, 1));
            int hold  = lng ? int'($urandom_range(28, 40)) : int'($urandom_range(7, 13));
            do_press(which, lng, hold, "rand");
        end

        // reset in the middle of a step burst
        if (m_run) do_press(1, 1'b0, 10, "pre_burst_halt");
        dif.keyStep_n = 1'b0;
        tick(10);
        dif.keyStep_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            tick(1);
            seen = dif.stepBusy;
        end
        check("burst_started", 32'(seen), 1);
        tick(3);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("abort.clkEnable", dif.clkEnable, 1);
        check("abort.stepBusy",  dif.stepBusy,  0);
        check("abort.running",   dif.running,   1);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check_state("post_reset");
        tick(20);
        check_state("post_reset_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
